// File: rtl/parcel_sequencer.sv
// Issue-side parcel buffer: splits 64-bit fetch words into 16-bit parcels and presents the
// current instruction (gh, i, j, k, LIP) with its parcel address P; restarts on branches.
module parcel_sequencer #(
  parameter int unsigned PADDR_W = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        i_word,
  input  logic               i_word_valid,
  output logic               o_word_ready,
  output logic [PADDR_W-3:0] o_fetch_addr,
  input  logic               i_issue,
  input  logic               i_branch,
  input  logic [PADDR_W-1:0] i_branch_paddr,
  output logic               o_valid,
  output logic [6:0]         o_instr,
  output logic [2:0]         o_cip_i,
  output logic [2:0]         o_cip_j,
  output logic [2:0]         o_cip_k,
  output logic [15:0]        o_lip,
  output logic               o_two_parcel,
  output logic [PADDR_W-1:0] o_p
);

  localparam int unsigned FA_W = PADDR_W - 2;

  logic [63:0]        w0_q, w0_d;
  logic [63:0]        w1_q, w1_d;
  logic [1:0]         count_q, count_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [FA_W-1:0]    fetch_addr_q, fetch_addr_d;
  logic [PADDR_W-1:0] p_q, p_d;

  logic [15:0] cip_c;
  logic [15:0] lip_c;
  logic        two_c;
  logic        valid_c;
  logic        ready_c;
  logic        accept_c;
  logic        fire_c;
  logic        pop_c;
  logic [2:0]  adv_c;
  logic [2:0]  ptr_sum_c;

  // Opcodes (octal gh) that carry a second parcel.
  function automatic logic is_two_parcel(input logic [6:0] gh);
    logic r;
    r = 1'b0;
    if (gh >= 7'o006 && gh <= 7'o021) r = 1'b1;
    if (gh == 7'o040 || gh == 7'o041) r = 1'b1;
    if (gh >= 7'o100 && gh <= 7'o137) r = 1'b1;
    return r;
  endfunction

  // Current/lower parcel selection and completeness of the current instruction.
  always_comb begin
    cip_c = 16'h0000;
    lip_c = 16'h0000;
    case (ptr_q)
      2'd0: begin cip_c = w0_q[63:48]; lip_c = w0_q[47:32]; end
      2'd1: begin cip_c = w0_q[47:32]; lip_c = w0_q[31:16]; end
      2'd2: begin cip_c = w0_q[31:16]; lip_c = w0_q[15:0];  end
      default: begin cip_c = w0_q[15:0]; lip_c = w1_q[63:48]; end
    endcase
    two_c   = is_two_parcel(cip_c[15:9]);
    valid_c = (count_q != 2'd0) && (!two_c || (ptr_q != 2'd3) || (count_q == 2'd2));
  end

  always_comb begin
    o_valid      = valid_c;
    o_instr      = 7'd0;
    o_cip_i      = 3'd0;
    o_cip_j      = 3'd0;
    o_cip_k      = 3'd0;
    o_lip        = 16'h0000;
    o_two_parcel = 1'b0;
    if (count_q != 2'd0) begin
      o_instr      = cip_c[15:9];
      o_cip_i      = cip_c[8:6];
      o_cip_j      = cip_c[5:3];
      o_cip_k      = cip_c[2:0];
      o_two_parcel = two_c;
      o_lip        = two_c ? lip_c : 16'h0000;
    end
  end

  assign ready_c      = (count_q < 2'd2) && !i_branch;
  assign o_word_ready = ready_c;
  assign o_fetch_addr = fetch_addr_q;
  assign o_p          = p_q;

  // Next-state: branch flushes; otherwise issue advance and word accept may coincide.
  always_comb begin
    w0_d         = w0_q;
    w1_d         = w1_q;
    count_d      = count_q;
    ptr_d        = ptr_q;
    fetch_addr_d = fetch_addr_q;
    p_d          = p_q;

    accept_c  = i_word_valid && ready_c;
    fire_c    = i_issue && valid_c && !i_branch;
    adv_c     = two_c ? 3'd2 : 3'd1;
    ptr_sum_c = {1'b0, ptr_q} + adv_c;
    pop_c     = fire_c && ptr_sum_c[2];

    if (i_branch) begin
      count_d      = 2'd0;
      ptr_d        = i_branch_paddr[1:0];
      p_d          = i_branch_paddr;
      fetch_addr_d = i_branch_paddr[PADDR_W-1:2];
    end else begin
      if (fire_c) begin
        ptr_d = ptr_sum_c[1:0];
        p_d   = p_q + PADDR_W'(adv_c);
      end
      if (accept_c) begin
        fetch_addr_d = fetch_addr_q + FA_W'(1);
      end
      case ({pop_c, accept_c})
        2'b10: begin
          w0_d    = w1_q;
          count_d = count_q - 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd0) w0_d = i_word;
          else                 w1_d = i_word;
          count_d = count_q + 2'd1;
        end
        // Accept only possible with one entry, which is the one being popped.
        2'b11: w0_d = i_word;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0_q         <= 64'd0;
      w1_q         <= 64'd0;
      count_q      <= 2'd0;
      ptr_q        <= 2'd0;
      fetch_addr_q <= '0;
      p_q          <= '0;
    end else begin
      w0_q         <= w0_d;
      w1_q         <= w1_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      fetch_addr_q <= fetch_addr_d;
      p_q          <= p_d;
    end
  end

endmodule

// File: tb/tb_parcel_sequencer.sv
// Scoreboard bench for parcel_sequencer: accepted parcels are queued with their expected
// addresses, and every cycle the presented instruction is compared against the queue head.
module tb_parcel_sequencer;

  localparam int unsigned PADDR_W = 22;

  logic               clk = 1'b0;
  logic               rst;
  logic [63:0]        i_word;
  logic               i_word_valid;
  logic               o_word_ready;
  logic [PADDR_W-3:0] o_fetch_addr;
  logic               i_issue;
  logic               i_branch;
  logic [PADDR_W-1:0] i_branch_paddr;
  logic               o_valid;
  logic [6:0]         o_instr;
  logic [2:0]         o_cip_i, o_cip_j, o_cip_k;
  logic [15:0]        o_lip;
  logic               o_two_parcel;
  logic [PADDR_W-1:0] o_p;

  parcel_sequencer #(.PADDR_W(PADDR_W)) dut (
    .clk(clk), .rst(rst), .i_word(i_word), .i_word_valid(i_word_valid),
    .o_word_ready(o_word_ready), .o_fetch_addr(o_fetch_addr), .i_issue(i_issue),
    .i_branch(i_branch), .i_branch_paddr(i_branch_paddr), .o_valid(o_valid),
    .o_instr(o_instr), .o_cip_i(o_cip_i), .o_cip_j(o_cip_j), .o_cip_k(o_cip_k),
    .o_lip(o_lip), .o_two_parcel(o_two_parcel), .o_p(o_p)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0]        pq[$];
  logic [PADDR_W-1:0] exp_p;
  logic [PADDR_W-3:0] exp_fa;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_two(input logic [6:0] g);
    return (g >= 7'o006 && g <= 7'o021) || g == 7'o040 || g == 7'o041 ||
           (g >= 7'o100 && g <= 7'o137);
  endfunction

  function automatic logic [15:0] par(input logic [6:0] g, input logic [8:0] ijk);
    return {g, ijk};
  endfunction

  function automatic logic [63:0] ow(input logic [7:0] s);
    return {par(7'o050, {1'b0, s}), par(7'o051, {1'b1, s}),
            par(7'o052, {1'b0, ~s}), par(7'o053, {1'b1, ~s})};
  endfunction

  // Words held in the DUT implied by the pending parcels and current pointer.
  function automatic int mcount();
    if (pq.size() == 0) return 0;
    return (pq.size() + int'(exp_p[1:0]) + 3) / 4;
  endfunction

  function automatic logic [15:0] parcel_of(input logic [63:0] w, input int idx);
    logic [63:0] t;
    t = w << (16 * idx);
    return t[63:48];
  endfunction

  task automatic model_reset();
    pq.delete();
    exp_p  = '0;
    exp_fa = '0;
  endtask

  task automatic step(input logic wv, input logic [63:0] w, input logic iss,
                      input logic br, input logic [PADDR_W-1:0] bpa);
    int          cnt;
    logic        rdy, ve, two;
    logic [15:0] cip;
    int          st;
    i_word_valid   = wv;
    i_word         = w;
    i_issue        = iss;
    i_branch       = br;
    i_branch_paddr = bpa;
    #1;
    cnt = mcount();
    rdy = (cnt < 2) && !br;
    chk("ready", 64'(o_word_ready), 64'(rdy));
    chk("fetch_addr", 64'(o_fetch_addr), 64'(exp_fa));
    chk("p", 64'(o_p), 64'(exp_p));
    ve = 1'b0; two = 1'b0; cip = 16'h0000;
    if (pq.size() > 0) begin
      cip = pq[0];
      two = is_two(cip[15:9]);
      ve  = !two || (pq.size() > 1);
    end
    chk("valid", 64'(o_valid), 64'(ve));
    chk("instr", 64'(o_instr), 64'(cip[15:9]));
    chk("cip_i", 64'(o_cip_i), 64'(cip[8:6]));
    chk("cip_j", 64'(o_cip_j), 64'(cip[5:3]));
    chk("cip_k", 64'(o_cip_k), 64'(cip[2:0]));
    chk("two", 64'(o_two_parcel), 64'(two));
    if (ve) chk("lip", 64'(o_lip), two ? 64'(pq[1]) : 64'd0);
    else if (pq.size() == 0) chk("lip_empty", 64'(o_lip), 64'd0);

    if (br) begin
      pq.delete();
      exp_p  = bpa;
      exp_fa = bpa[PADDR_W-1:2];
    end else begin
      if (iss && ve) begin
        void'(pq.pop_front());
        if (two) void'(pq.pop_front());
        exp_p = exp_p + (two ? PADDR_W'(2) : PADDR_W'(1));
      end
      if (wv && rdy) begin
        st = (pq.size() == 0) ? int'(exp_p[1:0]) : 0;
        for (int i = st; i < 4; i++) pq.push_back(parcel_of(w, i));
        exp_fa = exp_fa + 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_issue(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b1, 1'b0, '0);
  endtask

  logic [63:0] w1, wc, wd, wh, wj, wr;

  initial begin
    rst = 1'b1; i_word = '0; i_word_valid = 1'b0; i_issue = 1'b0;
    i_branch = 1'b0; i_branch_paddr = '0;
    model_reset();
    #3;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_word_ready), 64'd1);
    chk("rst_fa", 64'(o_fetch_addr), 64'd0);
    chk("rst_p", 64'(o_p), 64'd0);
    chk("rst_instr", 64'(o_instr), 64'd0);
    chk("rst_lip", 64'(o_lip), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-parcel 020 followed by its LIP, then two one-parcel instructions.
    w1 = {16'o020000, 16'o000001, par(7'o001, 9'o123), par(7'o002, 9'o456)};
    step(1'b1, w1, 1'b0, 1'b0, '0);
    chk("t1_instr", 64'(o_instr), 64'o020);
    chk("t1_lip", 64'(o_lip), 64'o000001);
    chk("t1_two", 64'(o_two_parcel), 64'd1);
    step(1'b0, 64'd0, 1'b1, 1'b0, '0);
    chk("t1_p_after", 64'(o_p), 64'd2);
    idle_issue(2);

    // Two buffered words, drained one parcel at a time.
    step(1'b1, ow(8'h11), 1'b0, 1'b0, '0);
    step(1'b1, ow(8'h22), 1'b0, 1'b0, '0);
    chk("t2_full", 64'(o_word_ready), 64'd0);
    idle_issue(4);
    chk("t2_ready_back", 64'(o_word_ready), 64'd1);
    chk("t2_fa", 64'(o_fetch_addr), 64'd3);
    idle_issue(4);

    // Two-parcel instruction straddling the word boundary.
    wc = {par(7'o050, 9'o001), par(7'o050, 9'o002), par(7'o050, 9'o003), par(7'o100, 9'o777)};
    wd = {16'hbeef, par(7'o060, 9'o011), par(7'o061, 9'o022), par(7'o062, 9'o033)};
    step(1'b1, wc, 1'b0, 1'b0, '0);
    idle_issue(3);
    chk("t3_wait", 64'(o_valid), 64'd0);
    step(1'b1, wd, 1'b0, 1'b0, '0);
    chk("t3_lip", 64'(o_lip), 64'hbeef);
    step(1'b0, 64'd0, 1'b1, 1'b0, '0);
    chk("t3_p", 64'(o_p), 64'd17);
    idle_issue(3);

    // Full buffer with a word held valid until space opens.
    step(1'b1, ow(8'h33), 1'b0, 1'b0, '0);
    step(1'b1, ow(8'h44), 1'b0, 1'b0, '0);
    step(1'b1, ow(8'h55), 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, ow(8'h55), 1'b1, 1'b0, '0);
    idle_issue(8);

    // Branch overriding issue and accept.
    wh = ow(8'h66);
    step(1'b1, wh, 1'b0, 1'b0, '0);
    step(1'b1, ow(8'h77), 1'b1, 1'b1, 22'h000106);
    chk("t5_fa", 64'(o_fetch_addr), 64'h41);
    chk("t5_p", 64'(o_p), 64'h106);
    chk("t5_valid", 64'(o_valid), 64'd0);
    wj = ow(8'h88);
    step(1'b1, wj, 1'b0, 1'b0, '0);
    chk("t5_cip", 64'({o_instr, o_cip_i, o_cip_j, o_cip_k}), 64'(wj[31:16]));
    idle_issue(2);

    // Asynchronous reset while two words are buffered.
    step(1'b1, ow(8'h99), 1'b0, 1'b0, '0);
    step(1'b1, ow(8'haa), 1'b0, 1'b0, '0);
    i_word_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(o_valid), 64'd0);
    chk("t6_instr", 64'(o_instr), 64'd0);
    chk("t6_p", 64'(o_p), 64'd0);
    chk("t6_ready", 64'(o_word_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(1'b1, ow(8'hbb), 1'b0, 1'b0, '0);
    idle_issue(4);

    // Random traffic, including two-parcel opcodes and occasional branches.
    for (int n = 0; n < 400; n++) begin
      wr = {$urandom, $urandom};
      step(($urandom % 4) != 0, wr, ($urandom % 3) != 0, ($urandom % 40) == 0,
           PADDR_W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
